// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit.
// funct3 encodings, FSM states and datapath width.
package ex_muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

endpackage

// File: rtl/ex_muldiv_core.sv
// One radix-2 iteration of the shared mul/div datapath.
// acc holds {hi, lo}: product halves, or {remainder, quotient}.
module ex_muldiv_core
  import ex_muldiv_pkg::*;
(
  input  logic              div_i,
  input  logic [XLEN-1:0]   op_b_i,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]}
           + (acc_i[0] ? {1'b0, op_b_i} : '0);
    rem_sh = acc_i[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, op_b_i};
    if (div_i) begin
      // borrow out means the trial subtract is undone
      if (diff[XLEN]) begin
        acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M mul/div unit: FSM, sign handling and result select.
// Stalls the front end while busy; one-cycle done strobe with result.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            freeze_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  import ex_muldiv_pkg::*;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2:0]          f3_q, f3_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic [XLEN-1:0]     res_q, res_d;

  logic [2*XLEN-1:0]   step;
  logic                sg1, sg2;
  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                is_div, div0, ovf;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quot, rem;

  ex_muldiv_core u_core (
    .div_i  (f3_q[2]),
    .op_b_i (opb_q),
    .acc_i  (acc_q),
    .acc_o  (step)
  );

  always_comb begin
    sg1 = 1'b0;
    sg2 = 1'b0;
    unique case (funct3_i)
      F3_MUL:    begin sg1 = 1'b1; sg2 = 1'b1; end
      F3_MULH:   begin sg1 = 1'b1; sg2 = 1'b1; end
      F3_MULHSU: begin sg1 = 1'b1; sg2 = 1'b0; end
      F3_MULHU:  begin sg1 = 1'b0; sg2 = 1'b0; end
      F3_DIV:    begin sg1 = 1'b1; sg2 = 1'b1; end
      F3_DIVU:   begin sg1 = 1'b0; sg2 = 1'b0; end
      F3_REM:    begin sg1 = 1'b1; sg2 = 1'b1; end
      F3_REMU:   begin sg1 = 1'b0; sg2 = 1'b0; end
    endcase
    a_neg  = sg1 & rs1_data_i[XLEN-1];
    b_neg  = sg2 & rs2_data_i[XLEN-1];
    a_mag  = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag  = b_neg ? -rs2_data_i : rs2_data_i;
    is_div = funct3_i[2];
    div0   = is_div && (rs2_data_i == '0);
    ovf    = is_div && sg1
           && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
           && (rs2_data_i == '1);
  end

  always_comb begin
    prod = negq_q ? -step : step;
    quot = negq_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem  = negr_q ? -step[2*XLEN-1:XLEN]
                  : step[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    f3_d    = f3_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    if (!freeze_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            f3_d   = funct3_i;
            negq_d = a_neg ^ b_neg;
            negr_d = a_neg;
            opb_d  = is_div ? b_mag : a_mag;
            acc_d  = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            cnt_d  = '0;
            if (div0) begin
              res_d   = funct3_i[1] ? rs1_data_i : '1;
              state_d = S_DONE;
            end else if (ovf) begin
              res_d   = funct3_i[1] ? '0 : rs1_data_i;
              state_d = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = S_DONE;
            unique case (f3_q)
              F3_MUL:    res_d = prod[XLEN-1:0];
              F3_MULH:   res_d = prod[2*XLEN-1:XLEN];
              F3_MULHSU: res_d = prod[2*XLEN-1:XLEN];
              F3_MULHU:  res_d = prod[2*XLEN-1:XLEN];
              F3_DIV:    res_d = quot;
              F3_DIVU:   res_d = quot;
              F3_REM:    res_d = rem;
              F3_REMU:   res_d = rem;
            endcase
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      f3_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      f3_q    <= f3_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
    end
  end

  assign busy_o   = ((state_q == S_IDLE) && start_i)
                  || (state_q == S_CALC);
  assign done_o   = (state_q == S_DONE);
  assign result_o = res_q;

endmodule
